// File: rtl/module_mux_seleccionador_reg.sv
`default_nettype none
// ============================================================================
//  Module      : module_mux_seleccionador_reg
//  Description : Registered one-hot channel selector for the display path.
//                Holds a strobe-loaded selection, flags multi-hot requests
//                with a sticky error, and registers the selected channel.
//                Optional auto-scan (macro MUX_AUTOSCAN_EN) rotates through
//                the channels every DWELL clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_mux_seleccionador_reg #(
  parameter int N_CH  = 3,
  parameter int W     = 8,
  parameter int DWELL = 50_000_000,
  localparam int IW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] data_in,
  input  logic [N_CH-1:0]   sel,
  input  logic              sel_ld,
  input  logic              freeze,
  input  logic              clr_err,
  input  logic              auto_en,
  output logic [W-1:0]      out,
  output logic              out_valid,
  output logic [IW-1:0]     ch_idx,
  output logic              err
);

  logic [N_CH-1:0] r_sel_q;
  logic [W-1:0]    r_out;
  logic            r_err;

  logic            w_sel_zero;
  logic            w_sel_onehot;
  logic [N_CH-1:0] w_man_sel;
  logic            w_man_err;
  logic [N_CH-1:0] w_sel_next;
  logic            w_set_err;
  logic [W-1:0]    w_sel_data;
  logic [IW-1:0]   w_idx;

  // Classify the incoming request: zero, one-hot, or multi-hot.
  assign w_sel_zero   = (sel == '0);
  assign w_sel_onehot = !w_sel_zero && ((sel & (sel - N_CH'(1))) == '0);

  // Manual load rules: one-hot loads, zero blanks, multi-hot keeps and flags.
  always_comb begin
    w_man_sel = r_sel_q;
    w_man_err = 1'b0;
    if (sel_ld) begin
      if (w_sel_zero) begin
        w_man_sel = '0;
      end else if (w_sel_onehot) begin
        w_man_sel = sel;
      end else begin
        w_man_err = 1'b1;
      end
    end
  end

`ifdef MUX_AUTOSCAN_EN
  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  localparam int            CW          = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] c_dwell_last = CW'(DWELL - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Mode register and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Mode transitions, dwell timing and the selection source for each mode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sel_next   = r_sel_q;
    w_set_err    = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        if (auto_en) begin
          // Entering auto-scan: start from channel 0 if nothing is selected.
          w_state_next = ST_AUTO;
          w_cnt_next   = '0;
          if (r_sel_q == '0) begin
            w_sel_next = N_CH'(1);
          end
        end else begin
          w_sel_next = w_man_sel;
          w_set_err  = w_man_err;
        end
      end
      ST_AUTO: begin
        if (!auto_en) begin
          // Leaving auto-scan keeps the current channel for manual use.
          w_state_next = ST_MANUAL;
          w_cnt_next   = '0;
        end else if (r_cnt == c_dwell_last) begin
          w_cnt_next = '0;
          w_sel_next = {r_sel_q[N_CH-2:0], r_sel_q[N_CH-1]};
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_MANUAL;
        w_cnt_next   = '0;
      end
    endcase
  end
`else
  // Manual-only build: auto-scan request and dwell setting have no effect.
  logic w_unused;
  assign w_unused   = auto_en & (DWELL >= 1);
  assign w_sel_next = w_man_sel;
  assign w_set_err  = w_man_err;
`endif

  // Data mux and index encoder driven by the stored one-hot selection.
  always_comb begin
    w_sel_data = '0;
    w_idx      = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel_data = w_sel_data | (data_in[i*W +: W] & {W{r_sel_q[i]}});
      if (r_sel_q[i]) begin
        w_idx = IW'(i);
      end
    end
  end

  // Selection, output data and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sel_q <= w_sel_next;
      if (!freeze) begin
        r_out <= w_sel_data;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = (r_sel_q != '0);
  assign ch_idx    = w_idx;
  assign err       = r_err;

endmodule
`default_nettype wire
